usart_tx_arb: RTL and testbench

USART_TX_ARB -- requirements
Module: usart_tx_arb

---
 rtl/usart_tx_arb_pkg.sv | 17 +
 rtl/usart_tx_arb_rr_pick.sv | 39 +++
 rtl/usart_tx_arb.sv | 204 ++++++++++++++++++++
 tb/tb_usart_tx_arb.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/usart_tx_arb_pkg.sv
// Shared definitions for the USART transmit arbiter.
//   usart_state_e : 2-bit FSM encoding (IDLE, START, WAIT_ING, WAIT_RDY)
//   BURST_LIMIT   : max consecutive grants to a locking owner (USART_ARB_LOCK_EN builds)
//   TX_DATA_RST   : tx_data value held while in reset
package usart_tx_arb_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StStart   = 2'd1,
    StWaitIng = 2'd2,
    StWaitRdy = 2'd3
  } usart_state_e;

  localparam int unsigned BURST_LIMIT = 16;
  localparam logic [7:0]  TX_DATA_RST = 8'hFF;

endpackage

// File: rtl/usart_tx_arb_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   i_req    [NREQ-1:0] : request flags
//   i_start  [2:0]      : index where the search begins (must be < NREQ)
//   o_onehot [NREQ-1:0] : one-hot winner (all zero when no request)
//   o_idx    [2:0]      : winner index (0 when no request)
//   o_valid             : at least one request present
module usart_rr_pick
  import usart_tx_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [2:0]      i_start,
  output logic [NREQ-1:0] o_onehot,
  output logic [2:0]      o_idx,
  output logic            o_valid
);

  int w_best_dist;

  // Winner is the requester with the smallest rotated distance from i_start.
  always_comb begin
    o_onehot    = '0;
    o_idx       = 3'd0;
    o_valid     = 1'b0;
    w_best_dist = int'(NREQ);
    for (int j = 0; j < int'(NREQ); j++) begin
      if (i_req[j] && (((j + int'(NREQ) - int'(i_start)) % int'(NREQ)) < w_best_dist)) begin
        w_best_dist = (j + int'(NREQ) - int'(i_start)) % int'(NREQ);
        o_onehot    = '0;
        o_onehot[j] = 1'b1;
        o_idx       = 3'(j);
        o_valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usart_tx_arb.sv
// Arbiter feeding a single USART transmitter from NREQ byte requesters.
// A winner's byte is latched and acked (ack visible the cycle after selection),
// tx_start pulses the following cycle, then the FSM tracks tx_ing / tx_rdy.
// A saturating timeout covers a transmitter that never finishes.
// Optional feature: define USART_ARB_LOCK_EN to let a requester holding req_lock
// keep the grant for up to BURST_LIMIT consecutive bytes.
// Ports:
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_req, i_req_data       : pending flags and packed bytes (byte i at [8i+7:8i])
//   i_req_lock              : burst-hold flags (lock builds only)
//   o_ack                   : one-hot one-cycle capture acknowledge
//   o_tx_data, o_tx_start   : byte and start pulse to the transmitter
//   i_tx_ing, i_tx_rdy      : transmitter in-progress flag and done pulse
//   o_owner                 : current / last granted index
//   o_busy, o_tmo_err       : not-idle flag, sticky timeout flag
module usart_tx_arb
  import usart_tx_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned TMO_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req,
  input  logic [8*NREQ-1:0] i_req_data,
  input  logic [NREQ-1:0]   i_req_lock,
  output logic [NREQ-1:0]   o_ack,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_ing,
  input  logic              i_tx_rdy,
  output logic [2:0]        o_owner,
  output logic              o_busy,
  output logic              o_tmo_err
);

  usart_state_e      r_state, w_state_nxt;
  logic [7:0]        r_tx_data, w_tx_data_nxt;
  logic [2:0]        r_owner, w_owner_nxt;
  logic [NREQ-1:0]   r_ack, w_ack_nxt;
  logic              r_tx_start, w_tx_start_nxt;
  logic              r_tmo_err, w_tmo_err_nxt;
  logic [TMO_W-1:0]  r_cnt, w_cnt_nxt;

  logic [2:0]        w_start_idx;
  logic [NREQ-1:0]   w_rr_onehot;
  logic [2:0]        w_rr_idx;
  logic              w_rr_valid;

  logic [NREQ-1:0]   w_win_onehot;
  logic [2:0]        w_win_idx;
  logic              w_win_valid;
  logic [7:0]        w_win_data;

  // Search begins one past the last owner; reset owner is NREQ-1 so it begins at 0.
  always_comb begin
    w_start_idx = (r_owner >= 3'(NREQ - 1)) ? 3'd0 : r_owner + 3'd1;
  end

  usart_rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .i_req   (i_req),
    .i_start (w_start_idx),
    .o_onehot(w_rr_onehot),
    .o_idx   (w_rr_idx),
    .o_valid (w_rr_valid)
  );

`ifdef USART_ARB_LOCK_EN
  logic [4:0]      r_burst, w_burst_nxt;
  logic            w_owner_req, w_owner_lock, w_lock_win;
  logic [NREQ-1:0] w_owner_onehot;

  always_comb begin
    w_owner_req    = 1'b0;
    w_owner_lock   = 1'b0;
    w_owner_onehot = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (r_owner == 3'(i)) begin
        w_owner_req       = i_req[i];
        w_owner_lock      = i_req_lock[i];
        w_owner_onehot[i] = 1'b1;
      end
    end
    w_lock_win   = w_owner_req && w_owner_lock && (r_burst < 5'(BURST_LIMIT));
    w_win_valid  = w_lock_win || w_rr_valid;
    w_win_idx    = w_lock_win ? r_owner : w_rr_idx;
    w_win_onehot = w_lock_win ? w_owner_onehot : w_rr_onehot;
  end

  // Burst counts grants to the current owner; an owner change restarts it at 1.
  always_comb begin
    w_burst_nxt = r_burst;
    if (r_state == StIdle && w_win_valid) begin
      if (w_win_idx != r_owner) begin
        w_burst_nxt = 5'd1;
      end else if (r_burst != 5'(BURST_LIMIT)) begin
        w_burst_nxt = r_burst + 5'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_burst <= 5'd0;
    end else begin
      r_burst <= w_burst_nxt;
    end
  end
`else
  logic w_unused_lock;

  always_comb begin
    w_unused_lock = ^i_req_lock;
    w_win_valid   = w_rr_valid;
    w_win_idx     = w_rr_idx;
    w_win_onehot  = w_rr_onehot;
  end
`endif

  always_comb begin
    w_win_data = 8'h00;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_win_onehot[i]) begin
        w_win_data = i_req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tx_data_nxt  = r_tx_data;
    w_owner_nxt    = r_owner;
    w_ack_nxt      = '0;
    w_tx_start_nxt = 1'b0;
    w_tmo_err_nxt  = r_tmo_err;
    w_cnt_nxt      = r_cnt;

    unique case (r_state)
      StIdle: begin
        // Stray tx_rdy / tx_ing are ignored here.
        if (w_win_valid) begin
          w_tx_data_nxt = w_win_data;
          w_ack_nxt     = w_win_onehot;
          w_owner_nxt   = w_win_idx;
          w_state_nxt   = StStart;
        end
      end
      StStart: begin
        w_tx_start_nxt = 1'b1;
        w_cnt_nxt      = '0;
        w_state_nxt    = StWaitIng;
      end
      StWaitIng, StWaitRdy: begin
        if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + TMO_W'(1);
        end
        // Timeout wins over progress; tx_rdy in WAIT_ING is ignored.
        if (r_cnt == '1) begin
          w_tmo_err_nxt = 1'b1;
          w_state_nxt   = StIdle;
        end else if (r_state == StWaitIng) begin
          if (i_tx_ing) begin
            w_state_nxt = StWaitRdy;
          end
        end else if (i_tx_rdy) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_tx_data  <= TX_DATA_RST;
      r_owner    <= 3'(NREQ - 1);
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_owner    <= w_owner_nxt;
      r_ack      <= w_ack_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tmo_err  <= w_tmo_err_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    o_ack      = r_ack;
    o_tx_data  = r_tx_data;
    o_tx_start = r_tx_start;
    o_owner    = r_owner;
    o_busy     = (r_state != StIdle);
    o_tmo_err  = r_tmo_err;
  end

endmodule

// File: tb/tb_usart_tx_arb.sv
// Directed bench for usart_tx_arb (NREQ=4, TMO_W=4 to keep the timeout short).
module tb_usart_tx_arb;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned TMO_W = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   ack;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_ing;
  logic              tx_rdy;
  logic [2:0]        owner;
  logic              busy;
  logic              tmo_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] data_b [NREQ] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};

  usart_tx_arb #(
    .NREQ (NREQ),
    .TMO_W(TMO_W)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_req_data(req_data),
    .i_req_lock(req_lock),
    .o_ack     (ack),
    .o_tx_data (tx_data),
    .o_tx_start(tx_start),
    .i_tx_ing  (tx_ing),
    .i_tx_rdy  (tx_rdy),
    .o_owner   (owner),
    .o_busy    (busy),
    .o_tmo_err (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, " ack"}, 32'(ack), 32'h0);
    check_eq({tag, " tx_start"}, 32'(tx_start), 32'h0);
    check_eq({tag, " tx_data"}, 32'(tx_data), 32'hFF);
    check_eq({tag, " owner"}, 32'(owner), 32'd3);
    check_eq({tag, " busy"}, 32'(busy), 32'h0);
    check_eq({tag, " tmo_err"}, 32'(tmo_err), 32'h0);
  endtask

  // Full frame: req must be set before the call; the arbiter is in IDLE.
  task automatic run_frame(input int exp_idx, input bit drop, input string tag);
    logic [NREQ-1:0] exp_oh;
    exp_oh          = '0;
    exp_oh[exp_idx] = 1'b1;
    tick();
    check_eq({tag, " ack"}, 32'(ack), 32'(exp_oh));
    check_eq({tag, " owner"}, 32'(owner), 32'(exp_idx));
    check_eq({tag, " data"}, 32'(tx_data), 32'(data_b[exp_idx]));
    check_eq({tag, " no start yet"}, 32'(tx_start), 32'h0);
    if (drop) req = '0;
    tick();
    check_eq({tag, " start"}, 32'(tx_start), 32'h1);
    check_eq({tag, " ack gone"}, 32'(ack), 32'h0);
    tx_ing = 1'b1;
    tick();
    tx_ing = 1'b0;
    check_eq({tag, " start gone"}, 32'(tx_start), 32'h0);
    check_eq({tag, " busy"}, 32'(busy), 32'h1);
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    check_eq({tag, " idle"}, 32'(busy), 32'h0);
    check_eq({tag, " data held"}, 32'(tx_data), 32'(data_b[exp_idx]));
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_lock = '0;
    tx_ing   = 1'b0;
    tx_rdy   = 1'b0;
    req_data = {data_b[3], data_b[2], data_b[1], data_b[0]};
    tick();
    tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();
    check_eq("post reset busy", 32'(busy), 32'h0);

    // All requesting: round robin from index 0.
    req = 4'b1111;
    run_frame(0, 1'b0, "rr0");
    run_frame(1, 1'b0, "rr1");
    run_frame(2, 1'b0, "rr2");
    run_frame(3, 1'b0, "rr3");
    run_frame(0, 1'b1, "rr4");

    // Single requester 0, data stability through a combined tx_ing+tx_rdy pulse.
    req = 4'b0001;
    tick();
    check_eq("single ack", 32'(ack), 32'h1);
    check_eq("single data", 32'(tx_data), 32'hA5);
    check_eq("single no start", 32'(tx_start), 32'h0);
    req = '0;
    tick();
    check_eq("single start", 32'(tx_start), 32'h1);
    tx_rdy = 1'b1;
    tick();
    check_eq("stray rdy in wait_ing", 32'(busy), 32'h1);
    tx_ing = 1'b1;
    tick();
    tx_ing = 1'b0;
    tx_rdy = 1'b0;
    check_eq("ing+rdy is ing", 32'(busy), 32'h1);
    tick();
    check_eq("wait_rdy data", 32'(tx_data), 32'hA5);
    check_eq("wait_rdy start low", 32'(tx_start), 32'h0);
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    check_eq("single idle", 32'(busy), 32'h0);
    check_eq("single data held", 32'(tx_data), 32'hA5);

    // Skipping non-requesters.
    req = 4'b1010;
    run_frame(1, 1'b1, "skip1");
    req = 4'b1001;
    run_frame(3, 1'b1, "skip3");

    // Stray tx_rdy in IDLE.
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    check_eq("stray busy", 32'(busy), 32'h0);
    check_eq("stray ack", 32'(ack), 32'h0);
    tick();
    check_eq("stray busy2", 32'(busy), 32'h0);
    check_eq("stray start", 32'(tx_start), 32'h0);

    // Timeout: tx_ing never rises.
    req = 4'b0100;
    tick();
    check_eq("tmo ack", 32'(ack), 32'h4);
    req = '0;
    tick();
    check_eq("tmo start", 32'(tx_start), 32'h1);
    for (int k = 0; k < 15; k++) tick();
    check_eq("tmo still busy", 32'(busy), 32'h1);
    check_eq("tmo not yet", 32'(tmo_err), 32'h0);
    tick();
    check_eq("tmo busy", 32'(busy), 32'h0);
    check_eq("tmo err", 32'(tmo_err), 32'h1);
    req = 4'b0001;
    run_frame(0, 1'b1, "after tmo");
    check_eq("tmo sticky", 32'(tmo_err), 32'h1);

    // Reset mid-frame in WAIT_RDY.
    req = 4'b0010;
    tick();
    req = '0;
    tick();
    tx_ing = 1'b1;
    tick();
    tx_ing = 1'b0;
    check_eq("pre-abort busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort async");
    tick();
    check_reset_vals("abort cycle");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("abort no ack", 32'(ack), 32'h0);
      check_eq("abort no start", 32'(tx_start), 32'h0);
      check_eq("abort idle", 32'(busy), 32'h0);
    end

    // Lock / burst behaviour.
    req      = 4'b0011;
    req_lock = 4'b0001;
    for (int k = 0; k < 17; k++) begin
`ifdef USART_ARB_LOCK_EN
      run_frame((k < 16) ? 0 : 1, 1'b0, $sformatf("lock%0d", k));
`else
      run_frame(k % 2, 1'b0, $sformatf("lock%0d", k));
`endif
    end
    req      = '0;
    req_lock = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
